// File: rtl/parking_pkg.sv
// Shared constants and FSM encoding for the Smart Parking System stages.
package parking_pkg;

    localparam int unsigned CapacityDefault = 16;
    localparam int unsigned CntWDefault     = 5;
    localparam int unsigned GateHoldDefault = 100;

    typedef enum logic {
        StIdle = 1'b0,
        StOpen = 1'b1
    } state_e;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: rise is high while level=1 and the previous sample was 0.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev_q, prev_d;

    // Next-state for the previous-level register and the edge output.
    always_comb begin
        prev_d = level;
        rise   = level & ~prev_q;
    end

    // Previous-level register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Occupancy counter and barrier controller for the parking lot.
// Optional sticky error output enabled by defining PARKING_ERR_EN.
module parking_occupancy_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY  = CapacityDefault,
    parameter int unsigned CNT_W     = CntWDefault,
    parameter int unsigned GATE_HOLD = GateHoldDefault
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_sensor,
    input  logic             exit_sensor,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] free_spots,
    output logic             full,
    output logic             empty,
    output logic             gate_open,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic             denied
`ifdef PARKING_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int unsigned      TimerW   = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;
    localparam logic [CNT_W-1:0] Cap      = CNT_W'(CAPACITY);
    localparam logic [TimerW-1:0] HoldLoad = TimerW'(GATE_HOLD - 1);

    logic rise_in, rise_out;
    logic exit_req, entry_req;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]  occ_q, occ_d, free_q, free_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              pend_in_q, pend_in_d, pend_out_q, pend_out_d;
    logic              entry_pulse_q, entry_pulse_d, exit_pulse_q, exit_pulse_d;
    logic              denied_q, denied_d;

    edge_detect u_entry_edge (
        .clk   (clk),
        .reset (reset),
        .level (entry_sensor),
        .rise  (rise_in)
    );

    edge_detect u_exit_edge (
        .clk   (clk),
        .reset (reset),
        .level (exit_sensor),
        .rise  (rise_out)
    );

    assign exit_req  = rise_out | pend_out_q;
    assign entry_req = rise_in | pend_in_q;

    // FSM next-state: serve one request per IDLE cycle (exit first), latch edges while open.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        occ_d         = occ_q;
        pend_in_d     = pend_in_q;
        pend_out_d    = pend_out_q;
        entry_pulse_d = 1'b0;
        exit_pulse_d  = 1'b0;
        denied_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (exit_req) begin
                    if (!empty_q) begin
                        occ_d        = occ_q - 1'b1;
                        exit_pulse_d = 1'b1;
                        state_d      = StOpen;
                        timer_d      = HoldLoad;
                    end
                    // A fresh edge arriving alongside a consumed pending request stays pending.
                    pend_out_d = pend_out_q & rise_out;
                    if (rise_in) begin
                        pend_in_d = 1'b1;
                    end
                end else if (entry_req) begin
                    if (!full_q) begin
                        occ_d         = occ_q + 1'b1;
                        entry_pulse_d = 1'b1;
                        state_d       = StOpen;
                        timer_d       = HoldLoad;
                    end else begin
                        denied_d = 1'b1;
                    end
                    pend_in_d = pend_in_q & rise_in;
                end
            end
            StOpen: begin
                if (rise_in) begin
                    pend_in_d = 1'b1;
                end
                if (rise_out) begin
                    pend_out_d = 1'b1;
                end
                if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        free_d  = Cap - occ_d;
        full_d  = (occ_d == Cap);
        empty_d = (occ_d == '0);
    end

    // State, counters, flags and output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            occ_q         <= '0;
            free_q        <= Cap;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            pend_in_q     <= 1'b0;
            pend_out_q    <= 1'b0;
            entry_pulse_q <= 1'b0;
            exit_pulse_q  <= 1'b0;
            denied_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            occ_q         <= occ_d;
            free_q        <= free_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            pend_in_q     <= pend_in_d;
            pend_out_q    <= pend_out_d;
            entry_pulse_q <= entry_pulse_d;
            exit_pulse_q  <= exit_pulse_d;
            denied_q      <= denied_d;
        end
    end

    assign occupancy   = occ_q;
    assign free_spots  = free_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign gate_open   = (state_q == StOpen);
    assign entry_pulse = entry_pulse_q;
    assign exit_pulse  = exit_pulse_q;
    assign denied      = denied_q;

`ifdef PARKING_ERR_EN
    logic err_q, err_d, err_set;

    // Sticky error: exit while empty, or an edge dropped because its pending flag is already set.
    always_comb begin
        err_set = ((state_q == StIdle) && exit_req && empty_q)
                || (rise_in && pend_in_q && ((state_q == StOpen) || exit_req))
                || (rise_out && pend_out_q && (state_q == StOpen));
        err_d   = err_q | err_set;
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed self-checking bench for parking_occupancy_ctrl (default parameters).
module tb_parking_occupancy_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       entry_sensor = 1'b0;
    logic       exit_sensor = 1'b0;
    logic [4:0] occupancy, free_spots;
    logic       full, empty, gate_open, entry_pulse, exit_pulse, denied;
`ifdef PARKING_ERR_EN
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    parking_occupancy_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .entry_sensor (entry_sensor),
        .exit_sensor  (exit_sensor),
        .occupancy    (occupancy),
        .free_spots   (free_spots),
        .full         (full),
        .empty        (empty),
        .gate_open    (gate_open),
        .entry_pulse  (entry_pulse),
        .exit_pulse   (exit_pulse),
        .denied       (denied)
`ifdef PARKING_ERR_EN
        ,
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic entry_edge();
        entry_sensor = 1'b1;
        tick();
        entry_sensor = 1'b0;
    endtask

    task automatic exit_edge();
        exit_sensor = 1'b1;
        tick();
        exit_sensor = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_gate_low(input int budget);
        int n = 0;
        while (gate_open && n < budget) begin
            tick();
            n++;
        end
        check_eq("gate_close_timeout", int'(gate_open), 0);
    endtask

    initial begin
        int cnt;

        // Reset values
        do_reset();
        check_eq("rst_occ", occupancy, 0);
        check_eq("rst_free", free_spots, 16);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_gate", gate_open, 0);
        check_eq("rst_pulses", {entry_pulse, exit_pulse, denied}, 0);
`ifdef PARKING_ERR_EN
        check_eq("rst_err", err, 0);
`endif

        // Single entry: pulse, counts, 100-cycle hold
        entry_edge();
        check_eq("e1_occ", occupancy, 1);
        check_eq("e1_free", free_spots, 15);
        check_eq("e1_pulse", entry_pulse, 1);
        check_eq("e1_empty", empty, 0);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            if (gate_open) cnt++;
            if (i == 1) check_eq("e1_pulse_width", entry_pulse, 0);
            tick();
        end
        check_eq("e1_hold_cycles", cnt, 100);
        check_eq("e1_gate_closed", gate_open, 0);

        // Fill to capacity, then deny
        for (int i = 0; i < 15; i++) begin
            entry_edge();
            wait_gate_low(200);
            tick();
        end
        check_eq("fill_occ", occupancy, 16);
        check_eq("fill_full", full, 1);
        check_eq("fill_free", free_spots, 0);
        entry_edge();
        check_eq("deny_pulse", denied, 1);
        check_eq("deny_occ", occupancy, 16);
        check_eq("deny_gate", gate_open, 0);
        check_eq("deny_entry_pulse", entry_pulse, 0);
        tick();
        check_eq("deny_width", denied, 0);
        check_eq("deny_gate2", gate_open, 0);

        // Simultaneous entry and exit at occupancy 3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            entry_edge();
            wait_gate_low(200);
            tick();
        end
        check_eq("sim_pre_occ", occupancy, 3);
        entry_sensor = 1'b1;
        exit_sensor  = 1'b1;
        tick();
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        check_eq("sim_exit_pulse", exit_pulse, 1);
        check_eq("sim_entry_pulse0", entry_pulse, 0);
        check_eq("sim_occ2", occupancy, 2);
        repeat (99) tick();
        check_eq("sim_gate_last", gate_open, 1);
        tick();
        check_eq("sim_gate_closed", gate_open, 0);
        check_eq("sim_idle_no_pulse", entry_pulse, 0);
        tick();
        check_eq("sim_entry_pulse", entry_pulse, 1);
        check_eq("sim_occ3", occupancy, 3);
        check_eq("sim_reopen", gate_open, 1);

        // Exit while empty
        do_reset();
        exit_edge();
        check_eq("empty_exit_pulse", exit_pulse, 0);
        check_eq("empty_exit_gate", gate_open, 0);
        check_eq("empty_exit_occ", occupancy, 0);
        tick();
        check_eq("empty_exit_gate2", gate_open, 0);
`ifdef PARKING_ERR_EN
        check_eq("empty_exit_err", err, 1);
`endif

        // Two entry edges during one OPEN period
        do_reset();
        entry_edge();
        check_eq("open_occ1", occupancy, 1);
        repeat (10) tick();
        entry_edge();
        tick();
`ifdef PARKING_ERR_EN
        check_eq("open_err_first", err, 0);
`endif
        entry_edge();
        tick();
`ifdef PARKING_ERR_EN
        check_eq("open_err_dup", err, 1);
`endif
        check_eq("open_occ_hold", occupancy, 1);
        wait_gate_low(200);
        tick();
        check_eq("open_served_pulse", entry_pulse, 1);
        check_eq("open_occ2", occupancy, 2);
        repeat (110) tick();
        check_eq("open_dropped_occ", occupancy, 2);
        check_eq("open_dropped_gate", gate_open, 0);

        // Reset in the middle of the hold, with an exit pending
        entry_edge();
        check_eq("mid_occ3", occupancy, 3);
        exit_edge();
        repeat (48) tick();
        check_eq("mid_gate_before", gate_open, 1);
        reset = 1'b1;
        tick();
        check_eq("mid_gate", gate_open, 0);
        check_eq("mid_occ", occupancy, 0);
        check_eq("mid_free", free_spots, 16);
        check_eq("mid_empty", empty, 1);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (exit_pulse || gate_open) cnt++;
        end
        check_eq("mid_pending_lost", cnt, 0);
`ifdef PARKING_ERR_EN
        check_eq("mid_err", err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
